// File: rtl/commit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// commit_ctrl_pkg
// Shared encodings for the in-order commit sequencer:
//   - commit type encodings driven by the ROB head (CT_REG / CT_STORE / CT_BRANCH)
//   - 2-bit FSM state encoding for commit_ctrl
//   - ROB index width that commit_ctrl's ROB_IDX_BITS parameter must match
// -----------------------------------------------------------------------------
package commit_ctrl_pkg;

  localparam int ROB_IDX_WIDTH = 4;

  // Commit types carried with each ROB entry. Encoding 3 is unused and is
  // retired like a plain register write.
  localparam logic [1:0] CT_REG    = 2'd0;
  localparam logic [1:0] CT_STORE  = 2'd1;
  localparam logic [1:0] CT_BRANCH = 2'd2;

  typedef enum logic [1:0] {
    S_COMMIT     = 2'd0,
    S_WAIT_STORE = 2'd1,
    S_FLUSH      = 2'd2
  } commit_state_t;

endpackage : commit_ctrl_pkg

// File: rtl/commit_ctrl.sv
// -----------------------------------------------------------------------------
// commit_ctrl
// In-order commit sequencer between the ROB head and the register file.
// Retires at most one instruction per cycle: a register write, a store
// handshake with the load/store buffer, or a branch check. A mispredicted
// branch produces a one-cycle roll_back pulse carrying the redirect PC.
//
// Ports:
//   clk, rst_in           clock, asynchronous active-high reset
//   rdy_in                global enable; low freezes state and zeroes outputs
//   head_*                ROB head entry (valid, ready, idx, type, dest, value,
//                         mispredict flag, redirect target)
//   head_pop              ROB drops its head this cycle
//   rob_in_en             register-file write strobe
//   rob_idx/dest/val_out  register-file write payload (copies of head_*)
//   st_commit_valid       ask the load/store buffer to perform the head store
//   st_commit_ready       load/store buffer accepts the store
//   st_done               memory write finished
//   roll_back             flush pulse, high for the cycle after a mispredict pop
//   rollback_pc           fetch redirect PC, valid while roll_back is high
//   commit_cnt            retired-instruction count, wraps modulo 2^32
// -----------------------------------------------------------------------------
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int ROB_IDX_BITS = ROB_IDX_WIDTH,
  parameter int DATA_BITS    = 32
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,

  input  logic                    head_valid,
  input  logic                    head_ready,
  input  logic [ROB_IDX_BITS-1:0] head_idx,
  input  logic [1:0]              head_type,
  input  logic [4:0]              head_dest,
  input  logic [DATA_BITS-1:0]    head_val,
  input  logic                    head_mispredict,
  input  logic [DATA_BITS-1:0]    head_target_pc,

  output logic                    head_pop,
  output logic                    rob_in_en,
  output logic [ROB_IDX_BITS-1:0] rob_idx_out,
  output logic [4:0]              rob_dest_out,
  output logic [DATA_BITS-1:0]    rob_val_out,

  output logic                    st_commit_valid,
  input  logic                    st_commit_ready,
  input  logic                    st_done,

  output logic                    roll_back,
  output logic [DATA_BITS-1:0]    rollback_pc,
  output logic [31:0]             commit_cnt
);

  commit_state_t            state_q;
  logic [DATA_BITS-1:0]     rb_pc_q;
  logic [31:0]              cnt_q;

  logic active;
  logic eligible;
  logic is_store;
  logic is_branch;

  // ---------------------------------------------------------------------------
  // Output decode. Strobes are combinational from the registered state and
  // the head inputs so a commit completes in the cycle the head is eligible.
  // Everything is gated by 'active' so outputs read 0 during reset (the reset
  // is asynchronous, so combinational paths must be masked too) and while
  // rdy_in is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    active          = rdy_in & ~rst_in;
    is_store        = (head_type == CT_STORE);
    is_branch       = (head_type == CT_BRANCH);
    eligible        = 1'b0;
    head_pop        = 1'b0;
    rob_in_en       = 1'b0;
    st_commit_valid = 1'b0;
    rob_idx_out     = '0;
    rob_dest_out    = '0;
    rob_val_out     = '0;
    roll_back       = 1'b0;
    rollback_pc     = '0;
    commit_cnt      = '0;

    if (active) begin
      eligible     = (state_q == S_COMMIT) && head_valid && head_ready;
      rob_idx_out  = head_idx;
      rob_dest_out = head_dest;
      rob_val_out  = head_val;
      roll_back    = (state_q == S_FLUSH);
      rollback_pc  = rb_pc_q;
      commit_cnt   = cnt_q;

      if (eligible) begin
        if (is_store) begin
          // Store pops only once the load/store buffer takes it.
          st_commit_valid = 1'b1;
          head_pop        = st_commit_ready;
        end else begin
          // Register ops (types 0 and 3) and branches; x0 is never written.
          head_pop  = 1'b1;
          rob_in_en = (head_dest != 5'd0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, redirect PC and retire counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_COMMIT;
      rb_pc_q <= '0;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (head_pop) begin
        cnt_q <= cnt_q + 32'd1;
      end

      unique case (state_q)
        S_COMMIT: begin
          if (head_pop && is_store) begin
            state_q <= S_WAIT_STORE;
          end else if (head_pop && is_branch && head_mispredict) begin
            rb_pc_q <= head_target_pc;
            state_q <= S_FLUSH;
          end
        end
        // st_done only counts once the store has popped; a pulse coincident
        // with the pop is seen in S_COMMIT and therefore ignored.
        S_WAIT_STORE: begin
          if (st_done) begin
            state_q <= S_COMMIT;
          end
        end
        S_FLUSH: begin
          state_q <= S_COMMIT;
        end
        default: begin
          state_q <= S_COMMIT;
        end
      endcase
    end
  end

endmodule : commit_ctrl

// File: tb/tb_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_commit_ctrl
// Directed scenarios for the commit sequencer followed by a randomized run
// checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_commit_ctrl;

  localparam int RB = 4;
  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          head_valid;
  logic          head_ready;
  logic [RB-1:0] head_idx;
  logic [1:0]    head_type;
  logic [4:0]    head_dest;
  logic [DB-1:0] head_val;
  logic          head_mispredict;
  logic [DB-1:0] head_target_pc;
  logic          head_pop;
  logic          rob_in_en;
  logic [RB-1:0] rob_idx_out;
  logic [4:0]    rob_dest_out;
  logic [DB-1:0] rob_val_out;
  logic          st_commit_valid;
  logic          st_commit_ready;
  logic          st_done;
  logic          roll_back;
  logic [DB-1:0] rollback_pc;
  logic [31:0]   commit_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  commit_ctrl #(.ROB_IDX_BITS(RB), .DATA_BITS(DB)) dut (
    .clk             (clk),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .head_valid      (head_valid),
    .head_ready      (head_ready),
    .head_idx        (head_idx),
    .head_type       (head_type),
    .head_dest       (head_dest),
    .head_val        (head_val),
    .head_mispredict (head_mispredict),
    .head_target_pc  (head_target_pc),
    .head_pop        (head_pop),
    .rob_in_en       (rob_in_en),
    .rob_idx_out     (rob_idx_out),
    .rob_dest_out    (rob_dest_out),
    .rob_val_out     (rob_val_out),
    .st_commit_valid (st_commit_valid),
    .st_commit_ready (st_commit_ready),
    .st_done         (st_done),
    .roll_back       (roll_back),
    .rollback_pc     (rollback_pc),
    .commit_cnt      (commit_cnt)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons in here)
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rdy_in          = 1'b1;
    head_valid      = 1'b0;
    head_ready      = 1'b0;
    head_idx        = '0;
    head_type       = 2'd0;
    head_dest       = 5'd0;
    head_val        = '0;
    head_mispredict = 1'b0;
    head_target_pc  = '0;
    st_commit_ready = 1'b0;
    st_done         = 1'b0;
  endtask

  task automatic set_head(input logic [1:0] t, input logic [RB-1:0] idx,
                          input logic [4:0] dest, input logic [DB-1:0] val,
                          input logic mp, input logic [DB-1:0] tgt);
    head_valid      = 1'b1;
    head_ready      = 1'b1;
    head_type       = t;
    head_idx        = idx;
    head_dest       = dest;
    head_val        = val;
    head_mispredict = mp;
    head_target_pc  = tgt;
  endtask

  task automatic do_reset();
    set_idle();
    rst_in = 1'b1;
    next_cycle();
    next_cycle();
    rst_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    set_idle();
    rst_in = 1'b1;
    // An eligible head during reset must not retire.
    set_head(2'd0, 4'd2, 5'd9, 32'hdead, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (head_pop !== 1'b0)    begin errors++; $display("FAIL reset_pop: got %0b want 0", head_pop); end
    checks++; if (rob_in_en !== 1'b0)   begin errors++; $display("FAIL reset_wr: got %0b want 0", rob_in_en); end
    checks++; if (roll_back !== 1'b0)   begin errors++; $display("FAIL reset_rb: got %0b want 0", roll_back); end
    checks++; if (commit_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt); end
    checks++; if (rollback_pc !== 32'd0) begin errors++; $display("FAIL reset_rbpc: got %0h want 0", rollback_pc); end
    next_cycle();
    rst_in = 1'b0;
    set_idle();
  endtask

  task automatic test_reg_commit();
    do_reset();
    set_head(2'd0, 4'd3, 5'd5, 32'h1234, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)       begin errors++; $display("FAIL reg_pop: got %0b want 1", head_pop); end
    checks++; if (rob_in_en !== 1'b1)      begin errors++; $display("FAIL reg_wr: got %0b want 1", rob_in_en); end
    checks++; if (rob_idx_out !== 4'd3)    begin errors++; $display("FAIL reg_idx: got %0d want 3", rob_idx_out); end
    checks++; if (rob_dest_out !== 5'd5)   begin errors++; $display("FAIL reg_dest: got %0d want 5", rob_dest_out); end
    checks++; if (rob_val_out !== 32'h1234) begin errors++; $display("FAIL reg_val: got %0h want 1234", rob_val_out); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (commit_cnt !== 32'd1) begin errors++; $display("FAIL reg_cnt: got %0d want 1", commit_cnt); end
    checks++; if (head_pop !== 1'b0)    begin errors++; $display("FAIL reg_idle_pop: got %0b want 0", head_pop); end
  endtask

  task automatic test_x0_dest();
    do_reset();
    set_head(2'd0, 4'd1, 5'd0, 32'h55, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL x0_pop: got %0b want 1", head_pop); end
    checks++; if (rob_in_en !== 1'b0) begin errors++; $display("FAIL x0_wr: got %0b want 0", rob_in_en); end
    next_cycle();
    // Encoding 3 retires like a register op.
    set_head(2'd3, 4'd2, 5'd7, 32'h77, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL t3_pop: got %0b want 1", head_pop); end
    checks++; if (rob_in_en !== 1'b1) begin errors++; $display("FAIL t3_wr: got %0b want 1", rob_in_en); end
    checks++; if (st_commit_valid !== 1'b0) begin errors++; $display("FAIL t3_stv: got %0b want 0", st_commit_valid); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (commit_cnt !== 32'd2) begin errors++; $display("FAIL x0_cnt: got %0d want 2", commit_cnt); end
  endtask

  task automatic test_store_handshake();
    do_reset();
    set_head(2'd1, 4'd4, 5'd0, 32'hab, 1'b0, 32'h0);
    st_commit_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (st_commit_valid !== 1'b1) begin errors++; $display("FAIL st_wait_valid[%0d]: got %0b want 1", i, st_commit_valid); end
      checks++; if (head_pop !== 1'b0)        begin errors++; $display("FAIL st_wait_pop[%0d]: got %0b want 0", i, head_pop); end
      next_cycle();
    end
    // Accept; st_done coincident with the pop must be ignored.
    st_commit_ready = 1'b1;
    st_done         = 1'b1;
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL st_pop: got %0b want 1", head_pop); end
    checks++; if (rob_in_en !== 1'b0) begin errors++; $display("FAIL st_wr: got %0b want 0", rob_in_en); end
    next_cycle();
    set_head(2'd0, 4'd5, 5'd4, 32'h99, 1'b0, 32'h0);
    st_commit_ready = 1'b0;
    st_done         = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (head_pop !== 1'b0)  begin errors++; $display("FAIL st_block_pop[%0d]: got %0b want 0", i, head_pop); end
      checks++; if (rob_in_en !== 1'b0) begin errors++; $display("FAIL st_block_wr[%0d]: got %0b want 0", i, rob_in_en); end
      next_cycle();
    end
    st_done = 1'b1;
    @(negedge clk);
    checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL st_done_cycle_pop: got %0b want 0", head_pop); end
    next_cycle();
    st_done = 1'b0;
    @(negedge clk);
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL st_resume_pop: got %0b want 1", head_pop); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (commit_cnt !== 32'd2) begin errors++; $display("FAIL st_cnt: got %0d want 2", commit_cnt); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_head(2'd2, 4'd6, 5'd1, 32'h104, 1'b1, 32'h200);
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)       begin errors++; $display("FAIL mp_pop: got %0b want 1", head_pop); end
    checks++; if (rob_in_en !== 1'b1)      begin errors++; $display("FAIL mp_wr: got %0b want 1", rob_in_en); end
    checks++; if (rob_dest_out !== 5'd1)   begin errors++; $display("FAIL mp_dest: got %0d want 1", rob_dest_out); end
    checks++; if (rob_val_out !== 32'h104) begin errors++; $display("FAIL mp_val: got %0h want 104", rob_val_out); end
    checks++; if (roll_back !== 1'b0)      begin errors++; $display("FAIL mp_rb_early: got %0b want 0", roll_back); end
    next_cycle();
    set_head(2'd0, 4'd7, 5'd2, 32'h22, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (roll_back !== 1'b1)        begin errors++; $display("FAIL mp_rb: got %0b want 1", roll_back); end
    checks++; if (rollback_pc !== 32'h200)   begin errors++; $display("FAIL mp_rbpc: got %0h want 200", rollback_pc); end
    checks++; if (head_pop !== 1'b0)         begin errors++; $display("FAIL mp_flush_pop: got %0b want 0", head_pop); end
    next_cycle();
    @(negedge clk);
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL mp_rb_end: got %0b want 0", roll_back); end
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL mp_resume_pop: got %0b want 1", head_pop); end
    next_cycle();
    // Correctly predicted branch, no link: no write, no flush.
    set_head(2'd2, 4'd8, 5'd0, 32'h0, 1'b0, 32'h300);
    @(negedge clk);
    checks++; if (rob_in_en !== 1'b0) begin errors++; $display("FAIL br_ok_wr: got %0b want 0", rob_in_en); end
    next_cycle();
    set_head(2'd0, 4'd9, 5'd3, 32'h33, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL br_ok_rb: got %0b want 0", roll_back); end
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL br_ok_next_pop: got %0b want 1", head_pop); end
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (commit_cnt !== 32'd4) begin errors++; $display("FAIL mp_cnt: got %0d want 4", commit_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    set_head(2'd0, 4'd1, 5'd6, 32'h66, 1'b0, 32'h0);
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (head_pop !== 1'b0)  begin errors++; $display("FAIL stall_pop[%0d]: got %0b want 0", i, head_pop); end
      checks++; if (rob_in_en !== 1'b0) begin errors++; $display("FAIL stall_wr[%0d]: got %0b want 0", i, rob_in_en); end
      next_cycle();
    end
    rdy_in = 1'b1;
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL stall_release_pop: got %0b want 1", head_pop); end
    checks++; if (rob_in_en !== 1'b1) begin errors++; $display("FAIL stall_release_wr: got %0b want 1", rob_in_en); end
    next_cycle();
    // Freeze in the middle of a flush; the pulse appears once rdy_in returns.
    set_head(2'd2, 4'd2, 5'd0, 32'h0, 1'b1, 32'h480);
    @(negedge clk);
    next_cycle();
    set_idle();
    rdy_in = 1'b0;
    @(negedge clk);
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL stall_flush_rb: got %0b want 0", roll_back); end
    next_cycle();
    rdy_in = 1'b1;
    @(negedge clk);
    checks++; if (roll_back !== 1'b1)      begin errors++; $display("FAIL stall_flush_resume: got %0b want 1", roll_back); end
    checks++; if (rollback_pc !== 32'h480) begin errors++; $display("FAIL stall_flush_pc: got %0h want 480", rollback_pc); end
    next_cycle();
    @(negedge clk);
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL stall_flush_end: got %0b want 0", roll_back); end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    set_head(2'd2, 4'd3, 5'd1, 32'h10, 1'b1, 32'h900);
    next_cycle();
    set_idle();
    @(negedge clk);
    checks++; if (roll_back !== 1'b1) begin errors++; $display("FAIL rf_pre_rb: got %0b want 1", roll_back); end
    #1 rst_in = 1'b1;
    #1;
    checks++; if (roll_back !== 1'b0)    begin errors++; $display("FAIL rf_rb: got %0b want 0", roll_back); end
    checks++; if (commit_cnt !== 32'd0)  begin errors++; $display("FAIL rf_cnt: got %0d want 0", commit_cnt); end
    checks++; if (rollback_pc !== 32'd0) begin errors++; $display("FAIL rf_rbpc: got %0h want 0", rollback_pc); end
    next_cycle();
    rst_in = 1'b0;
    set_head(2'd0, 4'd4, 5'd2, 32'h20, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (head_pop !== 1'b1)  begin errors++; $display("FAIL rf_after_pop: got %0b want 1", head_pop); end
    checks++; if (roll_back !== 1'b0) begin errors++; $display("FAIL rf_after_rb: got %0b want 0", roll_back); end
    next_cycle();
    set_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against a transaction-level model: the model only tracks
  // "a popped store is waiting for its memory write", "a redirect is due next
  // cycle", the retire count and the redirect PC.
  // ---------------------------------------------------------------------------
  task automatic test_random();
    bit          m_store_pending;
    bit          m_redirect_due;
    logic [31:0] m_cnt;
    logic [31:0] m_pc;
    bit          e_pop, e_wr, e_stv, e_rb, can_retire;
    do_reset();
    m_store_pending = 1'b0;
    m_redirect_due  = 1'b0;
    m_cnt           = 32'd0;
    m_pc            = 32'd0;
    for (int c = 0; c < 600; c++) begin
      rdy_in          = ($urandom_range(0, 9) != 0);
      head_valid      = ($urandom_range(0, 5) != 0);
      head_ready      = ($urandom_range(0, 4) != 0);
      head_idx        = RB'($urandom);
      head_type       = 2'($urandom);
      head_dest       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      head_val        = $urandom;
      head_mispredict = ($urandom_range(0, 2) == 0);
      head_target_pc  = $urandom;
      st_commit_ready = $urandom_range(0, 1) == 1;
      st_done         = ($urandom_range(0, 2) == 0);

      can_retire = rdy_in && !m_store_pending && !m_redirect_due && head_valid && head_ready;
      e_stv = can_retire && (head_type == 2'd1);
      e_pop = can_retire && ((head_type != 2'd1) || st_commit_ready);
      e_wr  = can_retire && (head_type != 2'd1) && (head_dest != 5'd0);
      e_rb  = rdy_in && m_redirect_due;

      @(negedge clk);
      checks++; if (head_pop !== e_pop)        begin errors++; $display("FAIL rnd_pop c=%0d: got %0b want %0b", c, head_pop, e_pop); end
      checks++; if (rob_in_en !== e_wr)        begin errors++; $display("FAIL rnd_wr c=%0d: got %0b want %0b", c, rob_in_en, e_wr); end
      checks++; if (st_commit_valid !== e_stv) begin errors++; $display("FAIL rnd_stv c=%0d: got %0b want %0b", c, st_commit_valid, e_stv); end
      checks++; if (roll_back !== e_rb)        begin errors++; $display("FAIL rnd_rb c=%0d: got %0b want %0b", c, roll_back, e_rb); end
      if (rdy_in) begin
        checks++; if (commit_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, commit_cnt, m_cnt); end
        if (e_rb) begin
          checks++; if (rollback_pc !== m_pc) begin errors++; $display("FAIL rnd_rbpc c=%0d: got %0h want %0h", c, rollback_pc, m_pc); end
        end
        if (e_wr) begin
          checks++; if (rob_val_out !== head_val || rob_dest_out !== head_dest)
            begin errors++; $display("FAIL rnd_payload c=%0d: got %0d/%0h want %0d/%0h", c, rob_dest_out, rob_val_out, head_dest, head_val); end
        end
      end

      @(posedge clk);
      if (rdy_in) begin
        if (m_redirect_due) begin
          m_redirect_due = 1'b0;
        end else if (m_store_pending) begin
          if (st_done) m_store_pending = 1'b0;
        end else if (e_pop) begin
          m_cnt = m_cnt + 32'd1;
          if (head_type == 2'd1) m_store_pending = 1'b1;
          else if (head_type == 2'd2 && head_mispredict) begin
            m_redirect_due = 1'b1;
            m_pc           = head_target_pc;
          end
        end
      end
      #1;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_in = 1'b1;
    test_reset();
    test_reg_commit();
    test_x0_dest();
    test_store_handshake();
    test_mispredict();
    test_stall();
    test_reset_in_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_commit_ctrl
